sbox_masked_driver: RTL and testbench

Sequencer that drives the 4-share masked Skinny-64 S-box (HPC2 gadgets with internal clock-gating controller, 13-cycle latency) one nibble at a time across a full 64-bit shared state. It loads each nibble's shares, restarts the S-box's gating controller, waits for the S-box `Synch` pulse, and captures the output shares. It is the initiator side of the S-box's `rst`/`Synch` handshake and sits between the cipher round datapath and one S-box instance.

---
 rtl/sbox_masked_driver_if.sv | 22 ++
 rtl/sbox_masked_driver.sv | 154 +++++++++++++++
 tb/tb_sbox_masked_driver.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sbox_masked_driver_if.sv
// Handshake bundle between the masked S-box sequencer (master) and one
// 4-share Skinny-64 S-box instance (slave).
interface sbox_masked_driver_if;
  localparam int unsigned NIB_W = 4;
  localparam int unsigned RND_W = 102;

  logic [NIB_W-1:0] SI_s0, SI_s1, SI_s2, SI_s3;
  logic             sbox_rst;
  logic [RND_W-1:0] Fresh;
  logic             Synch;
  logic [NIB_W-1:0] SO_s0, SO_s1, SO_s2, SO_s3;

  modport master (
    output SI_s0, SI_s1, SI_s2, SI_s3, sbox_rst, Fresh,
    input  Synch, SO_s0, SO_s1, SO_s2, SO_s3
  );

  modport slave (
    input  SI_s0, SI_s1, SI_s2, SI_s3, sbox_rst, Fresh,
    output Synch, SO_s0, SO_s1, SO_s2, SO_s3
  );
endinterface

// File: rtl/sbox_masked_driver.sv
// Walks a 4-share state through one masked S-box a nibble at a time, restarting
// the S-box per nibble and capturing its output shares on Synch.
module sbox_masked_driver #(
  parameter int unsigned NIBBLES = 16,
  parameter int unsigned LATENCY = 13,
  parameter int unsigned TIMEOUT = LATENCY + 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   in_s0,
  input  logic [4*NIBBLES-1:0]   in_s1,
  input  logic [4*NIBBLES-1:0]   in_s2,
  input  logic [4*NIBBLES-1:0]   in_s3,
  input  logic [101:0]           rnd_in,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [4*NIBBLES-1:0]   out_s0,
  output logic [4*NIBBLES-1:0]   out_s1,
  output logic [4*NIBBLES-1:0]   out_s2,
  output logic [4*NIBBLES-1:0]   out_s3,
  sbox_masked_driver_if.master   sb
);
  localparam int unsigned SHARES  = 4;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned STATE_W = NIB_W * NIBBLES;
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int unsigned CNT_W   = $clog2(((TIMEOUT > LATENCY) ? TIMEOUT : LATENCY) + 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_e;

  state_e                         state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [CNT_W-1:0]               wcnt_q, wcnt_d;
  logic                           err_q, err_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           sbox_rst_q, sbox_rst_d;
  logic [SHARES-1:0][STATE_W-1:0] shr_q, shr_d;
  logic [SHARES-1:0][STATE_W-1:0] out_q, out_d;
  logic [SHARES-1:0][NIB_W-1:0]   si_q, si_d;
  logic [SHARES-1:0][STATE_W-1:0] in_sh;
  logic [SHARES-1:0][NIB_W-1:0]   so_sh;

  assign in_sh = {in_s3, in_s2, in_s1, in_s0};
  assign so_sh = {sb.SO_s3, sb.SO_s2, sb.SO_s1, sb.SO_s0};

  // Next state, share latches and registered-output next values
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wcnt_d     = wcnt_q;
    err_d      = err_q;
    shr_d      = shr_q;
    out_d      = out_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    sbox_rst_d = 1'b0;
    si_d       = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          shr_d   = in_sh;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wcnt_d = CNT_W'(wcnt_q + 1'b1);
        if (sb.Synch) begin
          for (int unsigned k = 0; k < SHARES; k++) begin
            out_d[k][{idx_q, 2'b00} +: NIB_W] = so_sh[k];
          end
          if (idx_q == IDX_W'(NIBBLES - 1)) begin
            state_d = DONE;
          end else begin
            idx_d   = IDX_W'(idx_q + 1'b1);
            state_d = LOAD;
          end
        end else if (wcnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs follow the state being entered so they line up with it
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    sbox_rst_d = (state_d == IDLE) || (state_d == LOAD);
    if (state_d == LOAD) begin
      for (int unsigned k = 0; k < SHARES; k++) begin
        si_d[k] = shr_d[k][{idx_d, 2'b00} +: NIB_W];
      end
    end else if (state_d == WAIT) begin
      si_d = si_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      wcnt_q     <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sbox_rst_q <= 1'b1;
      shr_q      <= '0;
      out_q      <= '0;
      si_q       <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wcnt_q     <= wcnt_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sbox_rst_q <= sbox_rst_d;
      shr_q      <= shr_d;
      out_q      <= out_d;
      si_q       <= si_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign out_s0      = out_q[0];
  assign out_s1      = out_q[1];
  assign out_s2      = out_q[2];
  assign out_s3      = out_q[3];
  assign sb.SI_s0    = si_q[0];
  assign sb.SI_s1    = si_q[1];
  assign sb.SI_s2    = si_q[2];
  assign sb.SI_s3    = si_q[3];
  assign sb.sbox_rst = sbox_rst_q;
  // Randomness is consumed by the S-box in the same cycle it arrives
  assign sb.Fresh    = rnd_in;

endmodule

// File: tb/tb_sbox_masked_driver.sv
// Bench for sbox_masked_driver: behavioural masked S-box, layer scoreboard,
// and directed timeout / reset / protocol-robustness sequences.
module tb_sbox_masked_driver;
  localparam int unsigned NIB = 16;
  localparam int unsigned LAT = 13;
  localparam int unsigned TO  = LAT + 2;
  localparam int unsigned W   = 4 * NIB;
  localparam int unsigned LAYER_CYC = 1 + NIB * (LAT + 1);

  typedef struct {
    logic [63:0] x;
    logic [63:0] y;
  } vec_t;

  typedef struct {
    string       name;
    logic [63:0] recomb;
    logic        err;
    int unsigned cyc;
    int unsigned pulses;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [W-1:0] in_s0 = '0, in_s1 = '0, in_s2 = '0, in_s3 = '0;
  logic [101:0] rnd_in = '0;
  logic busy, done, err;
  logic [W-1:0] out_s0, out_s1, out_s2, out_s3;

  sbox_masked_driver_if sb ();

  sbox_masked_driver #(.NIBBLES(NIB), .LATENCY(LAT), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_s0(in_s0), .in_s1(in_s1), .in_s2(in_s2), .in_s3(in_s3),
    .rnd_in(rnd_in), .busy(busy), .done(done), .err(err),
    .out_s0(out_s0), .out_s1(out_s1), .out_s2(out_s2), .out_s3(out_s3),
    .sb(sb)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned done_cnt = 0;
  exp_t        sbq[$];
  logic [W-1:0] cur_s [4];
  vec_t        vecs [5];

  // Behavioural S-box: unmask, substitute, remask with fresh output shares
  logic [3:0] sbox_t [16] = '{4'hC, 4'h6, 4'h9, 4'h0, 4'h1, 4'hA, 4'h2, 4'hB,
                              4'h3, 4'h8, 4'h5, 4'hD, 4'h4, 4'hE, 4'h7, 4'hF};
  int unsigned mcnt = 0, nib_cur = 0, loads = 0;
  logic [3:0]  y_q = '0, m1 = '0, m2 = '0, m3 = '0;
  logic        block_en = 1'b0, spur_idle = 1'b0, spur_load = 1'b0, spur_load_en = 1'b0;
  logic [3:0]  si_x;

  assign si_x     = sb.SI_s0 ^ sb.SI_s1 ^ sb.SI_s2 ^ sb.SI_s3;
  assign sb.SO_s0 = y_q ^ m1 ^ m2 ^ m3;
  assign sb.SO_s1 = m1;
  assign sb.SO_s2 = m2;
  assign sb.SO_s3 = m3;
  assign sb.Synch = ((mcnt == LAT) && !(block_en && nib_cur == 5)) || spur_idle || spur_load;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!busy) loads <= 0;
    else if (sb.sbox_rst) loads <= loads + 1;
    if (sb.sbox_rst) begin
      mcnt    <= 1;
      nib_cur <= loads;
      y_q     <= sbox_t[si_x];
      m1      <= 4'($urandom);
      m2      <= 4'($urandom);
      m3      <= 4'($urandom);
    end else if (mcnt == LAT) begin
      mcnt <= 0;
    end else if (mcnt != 0) begin
      mcnt <= mcnt + 1;
    end
  end

  always @(negedge clk) rnd_in = 102'({$urandom, $urandom, $urandom, $urandom});

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Handshake monitor and done-time scoreboard
  int unsigned si_bad = 0;
  logic [15:0] si_now, si_exp, si_ref = '0;
  exp_t        e_mon;
  always @(negedge clk) begin
    si_now = {sb.SI_s3, sb.SI_s2, sb.SI_s1, sb.SI_s0};
    spur_load <= spur_load_en && busy && sb.sbox_rst;
    if (!busy) begin
      si_bad = 0;
    end else if (sb.sbox_rst) begin
      si_exp = {cur_s[3][4*loads +: 4], cur_s[2][4*loads +: 4],
                cur_s[1][4*loads +: 4], cur_s[0][4*loads +: 4]};
      if (si_now != si_exp) si_bad++;
      si_ref = si_now;
    end else if (!done && si_now != si_ref) begin
      si_bad++;
    end
    if (done) begin
      done_cnt++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        e_mon = sbq.pop_front();
        check({e_mon.name, "_recomb"}, out_s0 ^ out_s1 ^ out_s2 ^ out_s3, e_mon.recomb);
        check({e_mon.name, "_err"}, 64'(err), 64'(e_mon.err));
        check({e_mon.name, "_done_cycle"}, 64'(cyc), 64'(e_mon.cyc));
        check({e_mon.name, "_sbox_rst_pulses"}, 64'(loads), 64'(e_mon.pulses));
        check({e_mon.name, "_si_handshake"}, 64'(si_bad), 64'd0);
      end
    end
  end

  task automatic set_shares(input logic [63:0] x);
    cur_s[0] = {$urandom, $urandom};
    cur_s[1] = {$urandom, $urandom};
    cur_s[2] = {$urandom, $urandom};
    cur_s[3] = x ^ cur_s[0] ^ cur_s[1] ^ cur_s[2];
    in_s0 = cur_s[0]; in_s1 = cur_s[1]; in_s2 = cur_s[2]; in_s3 = cur_s[3];
  endtask

  task automatic wait_done(input int unsigned snap, input int unsigned budget, input string name);
    int unsigned n = 0;
    while (done_cnt == snap && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (done_cnt == snap) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done within %0d cycles expected done", name, budget);
      sbq.delete();
    end
  endtask

  // Called at a negedge while the DUT idles; returns just after the DONE negedge
  task automatic run_layer(input string name, input logic [63:0] x, input logic [63:0] y,
                           input logic e_err, input int unsigned lat, input int unsigned pulses,
                           input bit poke_start);
    exp_t e;
    int unsigned snap;
    snap = done_cnt;
    set_shares(x);
    e.name = name; e.recomb = y; e.err = e_err; e.cyc = cyc + lat; e.pulses = pulses;
    sbq.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_s0 = {$urandom, $urandom}; in_s1 = {$urandom, $urandom};
    in_s2 = {$urandom, $urandom}; in_s3 = {$urandom, $urandom};
    if (poke_start) begin
      repeat (29) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(snap, lat + 20, name);
  endtask

  task automatic check_reset_state(input string name);
    #1;
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_done"}, 64'(done), 64'd0);
    check({name, "_err"}, 64'(err), 64'd0);
    check({name, "_sbox_rst"}, 64'(sb.sbox_rst), 64'd1);
    check({name, "_si"}, 64'({sb.SI_s3, sb.SI_s2, sb.SI_s1, sb.SI_s0}), 64'd0);
    check({name, "_out_s0"}, out_s0, 64'd0);
    check({name, "_out_s1"}, out_s1, 64'd0);
    check({name, "_out_s2"}, out_s2, 64'd0);
    check({name, "_out_s3"}, out_s3, 64'd0);
    check({name, "_fresh_lo"}, sb.Fresh[63:0], rnd_in[63:0]);
    check({name, "_fresh_hi"}, 64'(sb.Fresh[101:64]), 64'(rnd_in[101:64]));
  endtask

  logic [63:0] prev, exp_y;
  int unsigned snap0;

  initial begin
    vecs[0] = '{64'h0123456789ABCDEF, 64'hC6901A2B385D4E7F};
    vecs[1] = '{64'h0000000000000000, 64'hCCCCCCCCCCCCCCCC};
    vecs[2] = '{64'h0000000000000000, 64'hCCCCCCCCCCCCCCCC};
    vecs[3] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
    vecs[4] = '{64'hFEDCBA9876543210, 64'hF7E4D583B2A1096C};
    cur_s[0] = '0; cur_s[1] = '0; cur_s[2] = '0; cur_s[3] = '0;
    prev = '0;

    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_layer($sformatf("layer%0d", i), vecs[i].x, vecs[i].y, 1'b0, LAYER_CYC, NIB, 1'b0);
      prev = vecs[i].y;
      @(negedge clk);
    end

    // Nibble 5 never answers: nibbles 0..4 are fresh, the rest keep old values
    block_en = 1'b1;
    exp_y = {prev[63:20], vecs[0].y[19:0]};
    run_layer("timeout", vecs[0].x, exp_y, 1'b1, 1 + 5*(LAT+1) + 1 + TO, 6, 1'b0);
    block_en = 1'b0;
    prev = exp_y;
    @(negedge clk);
    check("err_hold", 64'(err), 64'd1);

    // Spurious Synch in IDLE and LOAD, extra start during WAIT
    spur_idle = 1'b1;
    repeat (3) @(negedge clk);
    spur_idle = 1'b0;
    spur_load_en = 1'b1;
    run_layer("robust", vecs[4].x, vecs[4].y, 1'b0, LAYER_CYC, NIB, 1'b1);
    spur_load_en = 1'b0;
    @(negedge clk);

    // Reset at cycle 100 of a layer: abort without done
    snap0 = done_cnt;
    set_shares(vecs[0].x);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("midrst");
    repeat (300) @(negedge clk);
    check("midrst_no_done", 64'(done_cnt - snap0), 64'd0);
    run_layer("after_rst", vecs[3].x, vecs[3].y, 1'b0, LAYER_CYC, NIB, 1'b0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
